// File: rtl/bs_price_combine.sv
// Black-Scholes price combine: call = S*N(d1) - K*disc*N(d2),
// put = call - S + K*disc, using one shared norm unit twice.
// Ports: clk, reset (async, active-high), start/operands in,
//   norm_start/norm_d/norm_n/norm_done to the norm unit,
//   call_out/put_out/done/busy/sat/err results.
module bs_price_combine #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] k_in,
  input  logic [WIDTH-1:0] disc_in,
  input  logic [WIDTH-1:0] d1_in,
  input  logic [WIDTH-1:0] d2_in,
  output logic             norm_start,
  output logic [WIDTH-1:0] norm_d,
  input  logic [WIDTH-1:0] norm_n,
  input  logic             norm_done,
  output logic [WIDTH-1:0] call_out,
  output logic [WIDTH-1:0] put_out,
  output logic             done,
  output logic             busy,
  output logic             sat,
  output logic             err
);

  localparam int FRAC = WIDTH / 2;
  localparam int CW   = $clog2(TIMEOUT + 1);

  localparam logic [WIDTH-1:0] MAXV =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE,
    N1_REQ,
    N1_WAIT,
    N1_CLR,
    N2_REQ,
    N2_WAIT,
    N2_CLR,
    MUL_A,
    MUL_B,
    CALL,
    PUT,
    DONE,
    ABORT
  } state_t;

  // Result is {saturated, value}.
  function automatic logic [WIDTH:0] qmul(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-FRAC:0] hi;
    p  = {{WIDTH{a[WIDTH-1]}}, a}
       * {{WIDTH{b[WIDTH-1]}}, b};
    // Bits above the kept window must all match its sign bit.
    hi = p[2*WIDTH-1:WIDTH+FRAC-1];
    if (&hi || ~|hi)
      qmul = {1'b0, p[WIDTH+FRAC-1:FRAC]};
    else
      qmul = {1'b1, p[2*WIDTH-1] ? MINV : MAXV};
  endfunction

  function automatic logic [WIDTH:0] qadd(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sub
  );
    logic [WIDTH:0] ax;
    logic [WIDTH:0] bx;
    logic [WIDTH:0] sm;
    ax = {a[WIDTH-1], a};
    bx = {b[WIDTH-1], b};
    if (sub)
      bx = ~bx + {{WIDTH{1'b0}}, 1'b1};
    sm = ax + bx;
    if (sm[WIDTH] != sm[WIDTH-1])
      qadd = {1'b1, sm[WIDTH] ? MINV : MAXV};
    else
      qadd = {1'b0, sm[WIDTH-1:0]};
  endfunction

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] k_r;
  logic [WIDTH-1:0] disc_r;
  logic [WIDTH-1:0] d1_r;
  logic [WIDTH-1:0] d2_r;
  logic [WIDTH-1:0] nd1_r;
  logic [WIDTH-1:0] nd2_r;
  logic [WIDTH-1:0] sn_r;
  logic [WIDTH-1:0] kd_r;
  logic [WIDTH-1:0] kdn_r;
  logic [WIDTH-1:0] call_r;
  logic [CW-1:0]    cnt_r;
  logic             sat_r;
  logic             err_r;

  logic [WIDTH:0] m_sn;
  logic [WIDTH:0] m_kd;
  logic [WIDTH:0] m_kdn;
  logic [WIDTH:0] a_call;
  logic [WIDTH:0] a_tmp;
  logic [WIDTH:0] a_put;
  logic           to_hit;

  assign m_sn   = qmul(s_r, nd1_r);
  assign m_kd   = qmul(k_r, disc_r);
  assign m_kdn  = qmul(kd_r, nd2_r);
  assign a_call = qadd(sn_r, kdn_r, 1'b1);
  assign a_tmp  = qadd(call_r, s_r, 1'b1);
  assign a_put  = qadd(a_tmp[WIDTH-1:0], kd_r, 1'b0);
  assign to_hit = (cnt_r == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    norm_start = 1'b0;
    norm_d     = '0;
    done       = 1'b0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = N1_REQ;
      end
      N1_REQ: begin
        norm_start = 1'b1;
        norm_d     = d1_r;
        state_d    = N1_WAIT;
      end
      N1_WAIT: begin
        norm_d = d1_r;
        if (norm_done)
          state_d = N1_CLR;
        else if (to_hit)
          state_d = ABORT;
      end
      N1_CLR: begin
        norm_d = d1_r;
        if (!norm_done)
          state_d = N2_REQ;
      end
      N2_REQ: begin
        norm_start = 1'b1;
        norm_d     = d2_r;
        state_d    = N2_WAIT;
      end
      N2_WAIT: begin
        norm_d = d2_r;
        if (norm_done)
          state_d = N2_CLR;
        else if (to_hit)
          state_d = ABORT;
      end
      N2_CLR: begin
        norm_d = d2_r;
        if (!norm_done)
          state_d = MUL_A;
      end
      MUL_A: state_d = MUL_B;
      MUL_B: state_d = CALL;
      CALL:  state_d = PUT;
      PUT:   state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ABORT: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_r      <= '0;
      k_r      <= '0;
      disc_r   <= '0;
      d1_r     <= '0;
      d2_r     <= '0;
      nd1_r    <= '0;
      nd2_r    <= '0;
      sn_r     <= '0;
      kd_r     <= '0;
      kdn_r    <= '0;
      call_r   <= '0;
      cnt_r    <= '0;
      sat_r    <= 1'b0;
      err_r    <= 1'b0;
      call_out <= '0;
      put_out  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            s_r    <= s_in;
            k_r    <= k_in;
            disc_r <= disc_in;
            d1_r   <= d1_in;
            d2_r   <= d2_in;
            sat_r  <= 1'b0;
            err_r  <= 1'b0;
          end
        end
        N1_REQ, N2_REQ: cnt_r <= '0;
        N1_WAIT, N2_WAIT: begin
          if (norm_done) begin
            if (state_q == N1_WAIT)
              nd1_r <= norm_n;
            else
              nd2_r <= norm_n;
          end else if (to_hit) begin
            // Abort results are visible while in ABORT.
            err_r    <= 1'b1;
            call_out <= '0;
            put_out  <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        MUL_A: begin
          sn_r  <= m_sn[WIDTH-1:0];
          kd_r  <= m_kd[WIDTH-1:0];
          sat_r <= sat_r | m_sn[WIDTH] | m_kd[WIDTH];
        end
        MUL_B: begin
          kdn_r <= m_kdn[WIDTH-1:0];
          sat_r <= sat_r | m_kdn[WIDTH];
        end
        CALL: begin
          call_r <= a_call[WIDTH-1:0];
          sat_r  <= sat_r | a_call[WIDTH];
        end
        PUT: begin
          call_out <= call_r;
          put_out  <= a_put[WIDTH-1:0];
          sat_r    <= sat_r | a_tmp[WIDTH]
                    | a_put[WIDTH];
        end
        default: ;
      endcase
    end
  end

  assign sat = sat_r;
  assign err = err_r;

endmodule

// File: tb/tb_bs_price_combine.sv
// Directed bench for bs_price_combine with a 3-cycle norm model
// whose done is held high for 2 cycles.
module tb_bs_price_combine;

  localparam int W  = 32;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  s_in = '0;
  logic [W-1:0]  k_in = '0;
  logic [W-1:0]  disc_in = '0;
  logic [W-1:0]  d1_in = '0;
  logic [W-1:0]  d2_in = '0;
  logic          norm_start;
  logic [W-1:0]  norm_d;
  logic [W-1:0]  norm_n;
  logic          norm_done;
  logic [W-1:0]  call_out;
  logic [W-1:0]  put_out;
  logic          done;
  logic          busy;
  logic          sat;
  logic          err;

  bs_price_combine #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_in(s_in), .k_in(k_in), .disc_in(disc_in),
    .d1_in(d1_in), .d2_in(d2_in),
    .norm_start(norm_start), .norm_d(norm_d),
    .norm_n(norm_n), .norm_done(norm_done),
    .call_out(call_out), .put_out(put_out),
    .done(done), .busy(busy), .sat(sat), .err(err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [W-1:0] tb_d1 = 32'h0000_8000;
  logic [W-1:0] tb_d2 = 32'hFFFF_C000;
  logic [W-1:0] tb_n1 = '0;
  logic [W-1:0] tb_n2 = '0;
  bit           m_hang = 1'b0;

  // Norm model: done 3 cycles after the start pulse, held 2 cycles.
  int           m_cnt;
  int           m_hold;
  logic [W-1:0] m_d;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0;
      m_hold <= 0;
      m_d <= '0;
      norm_done <= 1'b0;
      norm_n <= '0;
    end else if (norm_start) begin
      m_cnt <= 3;
      m_d <= norm_d;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !m_hang) begin
        norm_done <= 1'b1;
        m_hold <= 2;
        norm_n <= (m_d == tb_d1) ? tb_n1 : tb_n2;
      end
    end else if (m_hold > 0) begin
      m_hold <= m_hold - 1;
      if (m_hold == 1)
        norm_done <= 1'b0;
    end
  end

  // Per-job record of norm_start cycles and done cycles.
  int           ns_cnt;
  int           done_cnt;
  logic [W-1:0] ns_d [0:3];
  logic         ns_nd [0:3];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ns_cnt <= 0;
      done_cnt <= 0;
    end else if (start && !busy) begin
      ns_cnt <= 0;
      done_cnt <= 0;
    end else begin
      if (norm_start) begin
        if (ns_cnt < 4) begin
          ns_d[ns_cnt] <= norm_d;
          ns_nd[ns_cnt] <= norm_done;
        end
        ns_cnt <= ns_cnt + 1;
      end
      if (done)
        done_cnt <= done_cnt + 1;
    end
  end

  task automatic pulse_start(
    input logic [W-1:0] s, input logic [W-1:0] k,
    input logic [W-1:0] dc, input logic [W-1:0] n1,
    input logic [W-1:0] n2
  );
    tb_n1 = n1;
    tb_n2 = n2;
    s_in = s;
    k_in = k;
    disc_in = dc;
    d1_in = tb_d1;
    d2_in = tb_d2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(
    input int maxc, output bit ok, output int cyc
  );
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < maxc; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({norm_start, done, busy, sat, err} !== 5'b0)
      $display("FAIL reset_ctl got %b exp 00000",
        {norm_start, done, busy, sat, err});
    else pass_cnt++;
    total_cnt++;
    if (call_out !== 32'h0)
      $display("FAIL reset_call got %h exp 0", call_out);
    else pass_cnt++;
    total_cnt++;
    if (put_out !== 32'h0)
      $display("FAIL reset_put got %h exp 0", put_out);
    else pass_cnt++;
    total_cnt++;
    if (norm_d !== 32'h0)
      $display("FAIL reset_nd got %h exp 0", norm_d);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int cyc;
    pulse_start(32'h0064_0000, 32'h0064_0000,
      32'h0001_0000, 32'h0000_A000, 32'h0000_8000);
    wait_done(200, ok, cyc);
    total_cnt++;
    if (ok !== 1'b1)
      $display("FAIL basic_done got %b exp 1", ok);
    else pass_cnt++;
    total_cnt++;
    if (call_out !== 32'h000C_8000)
      $display("FAIL basic_call got %h exp 000c8000",
        call_out);
    else pass_cnt++;
    total_cnt++;
    if (put_out !== 32'h000C_8000)
      $display("FAIL basic_put got %h exp 000c8000",
        put_out);
    else pass_cnt++;
    total_cnt++;
    if ({sat, err} !== 2'b00)
      $display("FAIL basic_flags got %b exp 00", {sat, err});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, busy} !== 2'b00)
      $display("FAIL basic_after got %b exp 00",
        {done, busy});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done_cnt !== 1)
      $display("FAIL basic_done_cnt got %0d exp 1",
        done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_disc_half();
    bit ok;
    int cyc;
    pulse_start(32'h0064_0000, 32'h0064_0000,
      32'h0000_8000, 32'h0000_A000, 32'h0000_8000);
    wait_done(200, ok, cyc);
    total_cnt++;
    if (ok !== 1'b1)
      $display("FAIL half_done got %b exp 1", ok);
    else pass_cnt++;
    total_cnt++;
    if (call_out !== 32'h0025_8000)
      $display("FAIL half_call got %h exp 00258000",
        call_out);
    else pass_cnt++;
    total_cnt++;
    if (put_out !== 32'hFFF3_8000)
      $display("FAIL half_put got %h exp fff38000",
        put_out);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_handshake();
    bit ok;
    int cyc;
    pulse_start(32'h0064_0000, 32'h0064_0000,
      32'h0001_0000, 32'h0000_A000, 32'h0000_8000);
    wait_done(200, ok, cyc);
    @(negedge clk);
    total_cnt++;
    if (ns_cnt !== 2)
      $display("FAIL hs_pulses got %0d exp 2", ns_cnt);
    else pass_cnt++;
    total_cnt++;
    if (ns_d[0] !== tb_d1)
      $display("FAIL hs_d1 got %h exp %h", ns_d[0], tb_d1);
    else pass_cnt++;
    total_cnt++;
    if (ns_d[1] !== tb_d2)
      $display("FAIL hs_d2 got %h exp %h", ns_d[1], tb_d2);
    else pass_cnt++;
    total_cnt++;
    if (ns_nd[1] !== 1'b0)
      $display("FAIL hs_drop got %b exp 0", ns_nd[1]);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    bit ok;
    int cyc;
    pulse_start(32'h0064_0000, 32'h7FFF_0000,
      32'h0002_0000, 32'h0001_0000, 32'h0000_0000);
    wait_done(200, ok, cyc);
    total_cnt++;
    if (call_out !== 32'h0064_0000)
      $display("FAIL sat_call got %h exp 00640000",
        call_out);
    else pass_cnt++;
    total_cnt++;
    if (put_out !== 32'h7FFF_FFFF)
      $display("FAIL sat_put got %h exp 7fffffff", put_out);
    else pass_cnt++;
    total_cnt++;
    if (sat !== 1'b1)
      $display("FAIL sat_flag got %b exp 1", sat);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    m_hang = 1'b1;
    pulse_start(32'h0064_0000, 32'h0064_0000,
      32'h0001_0000, 32'h0000_A000, 32'h0000_8000);
    wait_done(TO + 40, ok, cyc);
    total_cnt++;
    if (ok !== 1'b1)
      $display("FAIL to_done got %b exp 1", ok);
    else pass_cnt++;
    total_cnt++;
    if (cyc !== TO + 1)
      $display("FAIL to_cycles got %0d exp %0d", cyc, TO + 1);
    else pass_cnt++;
    total_cnt++;
    if (err !== 1'b1)
      $display("FAIL to_err got %b exp 1", err);
    else pass_cnt++;
    total_cnt++;
    if ({call_out, put_out} !== 64'h0)
      $display("FAIL to_zero got %h %h exp 0 0",
        call_out, put_out);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, busy, err} !== 3'b001)
      $display("FAIL to_after got %b exp 001",
        {done, busy, err});
    else pass_cnt++;
    m_hang = 1'b0;
    repeat (4) @(negedge clk);
    pulse_start(32'h0064_0000, 32'h0064_0000,
      32'h0001_0000, 32'h0000_A000, 32'h0000_8000);
    wait_done(200, ok, cyc);
    total_cnt++;
    if ({ok, err} !== 2'b10)
      $display("FAIL to_recover got %b exp 10", {ok, err});
    else pass_cnt++;
    total_cnt++;
    if (call_out !== 32'h000C_8000)
      $display("FAIL to_rec_call got %h exp 000c8000",
        call_out);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    bit ok;
    int cyc;
    pulse_start(32'h0064_0000, 32'h0064_0000,
      32'h0000_8000, 32'h0000_A000, 32'h0000_8000);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ns_cnt == 2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (ok !== 1'b1)
      $display("FAIL ign_reach got %b exp 1", ok);
    else pass_cnt++;
    s_in = 32'h1234_0000;
    k_in = 32'h0001_0000;
    disc_in = 32'h0003_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, ok, cyc);
    total_cnt++;
    if (call_out !== 32'h0025_8000)
      $display("FAIL ign_call got %h exp 00258000",
        call_out);
    else pass_cnt++;
    total_cnt++;
    if (put_out !== 32'hFFF3_8000)
      $display("FAIL ign_put got %h exp fff38000", put_out);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({done_cnt, ns_cnt} !== {32'd1, 32'd2})
      $display("FAIL ign_counts got %0d %0d exp 1 2",
        done_cnt, ns_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    pulse_start(32'h0064_0000, 32'h0064_0000,
      32'h0001_0000, 32'h0000_A000, 32'h0000_8000);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ns_cnt == 2 && norm_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({ok, busy} !== 2'b11)
      $display("FAIL rm_busy got %b exp 11", {ok, busy});
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({call_out, put_out} !== 64'h0)
      $display("FAIL rm_zero got %h %h exp 0 0",
        call_out, put_out);
    else pass_cnt++;
    total_cnt++;
    if ({norm_start, done, busy, sat, err} !== 5'b0)
      $display("FAIL rm_ctl got %b exp 00000",
        {norm_start, done, busy, sat, err});
    else pass_cnt++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    pulse_start(32'h0064_0000, 32'h0064_0000,
      32'h0000_8000, 32'h0000_A000, 32'h0000_8000);
    wait_done(200, ok, cyc);
    total_cnt++;
    if ({ok, call_out} !== {1'b1, 32'h0025_8000})
      $display("FAIL rm_call got %b %h exp 1 00258000",
        ok, call_out);
    else pass_cnt++;
    total_cnt++;
    if (put_out !== 32'hFFF3_8000)
      $display("FAIL rm_put got %h exp fff38000", put_out);
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_disc_half();
    test_handshake();
    test_saturate();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
